div_share_arbiter: RTL and testbench

DIV_SHARE_ARBITER -- requirements
Module: div_share_arbiter

---
 rtl/div_share_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_div_share_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// Round-robin arbiter that time-shares one external Q4.12 divider among NUM_REQ requesters.
// Handles divide-by-zero locally and returns an error response if the divider never completes.
module div_share_arbiter #(
  parameter int WIDTH       = 16,
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_num,
  input  logic [NUM_REQ*WIDTH-1:0]   req_den,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [WIDTH-1:0]           rsp_quotient,
  output logic                       rsp_dz,
  output logic                       rsp_err,
  output logic                       div_start,
  output logic [WIDTH-1:0]           div_numerator,
  output logic [WIDTH-1:0]           div_denominator,
  input  logic [WIDTH-1:0]           div_quotient,
  input  logic                       div_done
);

  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0]      CNT_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [NUM_REQ-1:0] ONE      = {{(NUM_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE, RESP} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 div_start_q, div_start_d;
  logic [WIDTH-1:0]     num_q, num_d;
  logic [WIDTH-1:0]     den_q, den_d;
  logic [WIDTH-1:0]     res_q, res_d;
  logic                 res_err_q, res_err_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_quotient_q, rsp_quotient_d;
  logic                 rsp_dz_q, rsp_dz_d;
  logic                 rsp_err_q, rsp_err_d;

  logic [WIDTH-1:0]     num_arr [NUM_REQ];
  logic [WIDTH-1:0]     den_arr [NUM_REQ];
  logic [GW-1:0]        sel;
  logic [GW-1:0]        idx;
  logic                 sel_any;
  logic                 accept;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign num_arr[gi] = req_num[gi*WIDTH +: WIDTH];
    assign den_arr[gi] = req_den[gi*WIDTH +: WIDTH];
  end

  // Scan from farthest to nearest so the nearest valid requester after last_grant wins.
  always_comb begin
    sel     = last_grant_q;
    idx     = last_grant_q;
    sel_any = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = GW'((int'(last_grant_q) + k) % NUM_REQ);
      if (req_valid[idx]) begin
        sel     = idx;
        sel_any = 1'b1;
      end
    end
  end

  assign req_ready = (reset && state_q == IDLE && sel_any) ? (ONE << sel) : '0;
  assign accept    = |(req_valid & req_ready);

  always_comb begin
    state_d        = state_q;
    last_grant_d   = last_grant_q;
    grant_d        = grant_q;
    cnt_d          = cnt_q;
    div_start_d    = div_start_q;
    num_d          = num_q;
    den_d          = den_q;
    res_d          = res_q;
    res_err_d      = res_err_q;
    rsp_valid_d    = '0;
    rsp_quotient_d = rsp_quotient_q;
    rsp_dz_d       = rsp_dz_q;
    rsp_err_d      = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_d = sel;
          num_d   = num_arr[sel];
          den_d   = den_arr[sel];
          if (den_arr[sel] == '0) begin
            state_d        = RESP;
            rsp_valid_d    = ONE << sel;
            rsp_quotient_d = '0;
            rsp_dz_d       = 1'b1;
            rsp_err_d      = 1'b0;
          end else begin
            state_d     = BUSY;
            div_start_d = 1'b1;
            cnt_d       = '0;
          end
        end
      end
      BUSY: begin
        // div_done is checked first so it wins over a coincident timeout.
        if (div_done) begin
          res_d       = div_quotient;
          res_err_d   = 1'b0;
          div_start_d = 1'b0;
          state_d     = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          res_d       = '0;
          res_err_d   = 1'b1;
          div_start_d = 1'b0;
          state_d     = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        if (!div_done) begin
          state_d        = RESP;
          rsp_valid_d    = ONE << grant_q;
          rsp_quotient_d = res_q;
          rsp_dz_d       = 1'b0;
          rsp_err_d      = res_err_q;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      last_grant_q   <= GW'(NUM_REQ - 1);
      grant_q        <= '0;
      cnt_q          <= '0;
      div_start_q    <= 1'b0;
      num_q          <= '0;
      den_q          <= '0;
      res_q          <= '0;
      res_err_q      <= 1'b0;
      rsp_valid_q    <= '0;
      rsp_quotient_q <= '0;
      rsp_dz_q       <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_grant_q   <= last_grant_d;
      grant_q        <= grant_d;
      cnt_q          <= cnt_d;
      div_start_q    <= div_start_d;
      num_q          <= num_d;
      den_q          <= den_d;
      res_q          <= res_d;
      res_err_q      <= res_err_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_quotient_q <= rsp_quotient_d;
      rsp_dz_q       <= rsp_dz_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

  assign rsp_valid       = rsp_valid_q;
  assign rsp_quotient    = rsp_quotient_q;
  assign rsp_dz          = rsp_dz_q;
  assign rsp_err         = rsp_err_q;
  assign div_start       = div_start_q;
  assign div_numerator   = num_q;
  assign div_denominator = den_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter with a 3-cycle stub divider that can be told to hang.
module tb_div_share_arbiter;
  localparam int W  = 16;
  localparam int N  = 4;
  localparam int TO = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_num = '0;
  logic [N*W-1:0] req_den = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [W-1:0]   rsp_quotient;
  logic           rsp_dz;
  logic           rsp_err;
  logic           div_start;
  logic [W-1:0]   div_numerator;
  logic [W-1:0]   div_denominator;
  logic [W-1:0]   div_quotient;
  logic           div_done;

  int n_checks = 0;
  int n_fail   = 0;
  bit hang     = 1'b0;
  int dcnt;

  div_share_arbiter #(.WIDTH(W), .NUM_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_num(req_num), .req_den(req_den),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient),
    .rsp_dz(rsp_dz), .rsp_err(rsp_err), .div_start(div_start),
    .div_numerator(div_numerator), .div_denominator(div_denominator),
    .div_quotient(div_quotient), .div_done(div_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] q412(input logic [15:0] a, input logic [15:0] b);
    int n;
    int d;
    n = $signed(a);
    d = $signed(b);
    if (d == 0) return 16'h0;
    return 16'((n * 4096) / d);
  endfunction

  // Stub divider: done rises on the third cycle of start, falls once start drops.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_done     <= 1'b0;
      div_quotient <= '0;
      dcnt         <= 0;
    end else if (!div_start) begin
      div_done <= 1'b0;
      dcnt     <= 0;
    end else if (!hang && !div_done) begin
      if (dcnt == 2) begin
        div_done     <= 1'b1;
        div_quotient <= q412(div_numerator, div_denominator);
      end
      dcnt <= dcnt + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          req;
    logic [15:0] num;
    logic [15:0] den;
    logic [15:0] exp_q;
    logic        exp_dz;
    logic        exp_err;
    int          exp_start;
  } vec_t;

  vec_t vecs[6];

  task automatic run_txn(input vec_t v, input int id);
    int cyc;
    int lat;
    int start_cyc;
    bit acc;
    bit got;
    logic [N-1:0] rv;
    logic [W-1:0] q;
    logic dz;
    logic er;
    @(negedge clk);
    req_num[v.req*W +: W] = v.num;
    req_den[v.req*W +: W] = v.den;
    req_valid = '0;
    req_valid[v.req] = 1'b1;
    acc = 1'b0;
    for (cyc = 0; cyc < 20 && !acc; cyc++) begin
      #1;
      if (req_ready[v.req]) acc = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("t%0d_accept", id), 64'(acc), 64'd1);
    if (acc) check($sformatf("t%0d_ready_onehot", id), 64'(req_ready), 64'(4'b0001 << v.req));
    @(negedge clk);
    req_valid = '0;
    got = 1'b0; cyc = 0; lat = 0; start_cyc = 0;
    rv = '0; q = '0; dz = 1'b0; er = 1'b0;
    while (!got && cyc < 200) begin
      if (div_start) start_cyc++;
      if (rsp_valid != '0) begin
        got = 1'b1; rv = rsp_valid; q = rsp_quotient; dz = rsp_dz; er = rsp_err;
        lat = cyc + 1;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    $display("txn %0d: req=%0d num=%h den=%h -> rsp_valid=%b q=%h dz=%b err=%b start_cycles=%0d",
             id, v.req, v.num, v.den, rv, q, dz, er, start_cyc);
    check($sformatf("t%0d_rsp_valid", id), 64'(rv), 64'(4'b0001 << v.req));
    check($sformatf("t%0d_quotient", id), 64'(q), 64'(v.exp_q));
    check($sformatf("t%0d_dz", id), 64'(dz), 64'(v.exp_dz));
    check($sformatf("t%0d_err", id), 64'(er), 64'(v.exp_err));
    check($sformatf("t%0d_start_cycles", id), 64'(start_cyc), 64'(v.exp_start));
    if (v.exp_dz) check($sformatf("t%0d_dz_latency_le2", id), 64'(lat <= 2), 64'd1);
    @(negedge clk);
    check($sformatf("t%0d_rsp_one_cycle", id), 64'(rsp_valid), 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [W-1:0] rr_q [5];
    int           rr_id [5];
    int           k;
    int           cyc;
    bit           bad_rsp;
    bit           acc;

    vecs[0] = '{req: 2, num: 16'h1800, den: 16'h0800, exp_q: 16'h3000, exp_dz: 1'b0, exp_err: 1'b0, exp_start: 4};
    vecs[1] = '{req: 1, num: 16'hF000, den: 16'h0800, exp_q: 16'hE000, exp_dz: 1'b0, exp_err: 1'b0, exp_start: 4};
    vecs[2] = '{req: 3, num: 16'h1234, den: 16'h0000, exp_q: 16'h0000, exp_dz: 1'b1, exp_err: 1'b0, exp_start: 0};
    vecs[3] = '{req: 0, num: 16'hE000, den: 16'hF800, exp_q: 16'h4000, exp_dz: 1'b0, exp_err: 1'b0, exp_start: 4};
    vecs[4] = '{req: 2, num: 16'h0400, den: 16'h2000, exp_q: 16'h0200, exp_dz: 1'b0, exp_err: 1'b0, exp_start: 4};
    vecs[5] = '{req: 1, num: 16'h1000, den: 16'h0800, exp_q: 16'h2000, exp_dz: 1'b0, exp_err: 1'b0, exp_start: 4};
    rr_q  = '{16'h1000, 16'h2000, 16'h3000, 16'h4000, 16'h1000};
    rr_id = '{0, 1, 2, 3, 0};

    // Reset state, including req_ready held low while reset is active.
    repeat (2) @(negedge clk);
    req_valid = 4'b1111;
    #1;
    check("reset_outputs", {req_ready, rsp_valid, rsp_quotient, rsp_dz, rsp_err, div_start,
                            div_numerator, div_denominator}, 64'd0);
    req_valid = '0;
    @(negedge clk);
    reset = 1'b1;

    // Round robin with all four held valid: 0,1,2,3,0.
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req_num[i*W +: W] = 16'((i + 1) * 16'h1000);
      req_den[i*W +: W] = 16'h1000;
    end
    req_valid = 4'b1111;
    k = 0; cyc = 0;
    while (k < 5 && cyc < 500) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid != '0) begin
        $display("rr %0d: rsp_valid=%b q=%h", k, rsp_valid, rsp_quotient);
        check($sformatf("rr%0d_grant", k), 64'(rsp_valid), 64'(4'b0001 << rr_id[k]));
        check($sformatf("rr%0d_quotient", k), 64'(rsp_quotient), 64'(rr_q[k]));
        k++;
        if (k == 5) req_valid = '0;
      end
    end
    check("rr_count", 64'(k), 64'd5);
    req_valid = '0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) run_txn(vecs[i], i);

    // Hung divider -> error response after TO cycles of start, then normal service.
    hang = 1'b1;
    run_txn('{req: 0, num: 16'h1000, den: 16'h1000, exp_q: 16'h0000, exp_dz: 1'b0, exp_err: 1'b1, exp_start: TO}, 10);
    hang = 1'b0;
    run_txn(vecs[5], 11);

    // Reset pulsed mid-BUSY abandons the request; req0 then wins first.
    hang = 1'b1;
    @(negedge clk);
    req_num[2*W +: W] = 16'h1800;
    req_den[2*W +: W] = 16'h0800;
    req_valid = 4'b0100;
    acc = 1'b0;
    for (int c = 0; c < 20 && !acc; c++) begin
      #1;
      if (req_ready[2]) acc = 1'b1;
      else @(negedge clk);
    end
    check("rb_accept", 64'(acc), 64'd1);
    repeat (4) @(negedge clk);
    req_valid = '0;
    check("rb_busy_start", 64'(div_start), 64'd1);
    reset = 1'b0;
    #1;
    check("rb_outputs_cleared", {req_ready, rsp_valid, rsp_quotient, rsp_dz, rsp_err, div_start,
                                 div_numerator, div_denominator}, 64'd0);
    hang = 1'b0;
    bad_rsp = 1'b0;
    req_num[0 +: W] = 16'h0800;
    req_den[0 +: W] = 16'h1000;
    req_valid = 4'b0101;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid != '0) bad_rsp = 1'b1;
    end
    reset = 1'b1;
    #1;
    check("rb_first_grant", 64'(req_ready), 64'(4'b0001));
    @(negedge clk);
    req_valid = '0;
    k = 0;
    for (int c = 0; c < 50 && k == 0; c++) begin
      if (rsp_valid != '0) begin
        k = 1;
        $display("rb: rsp_valid=%b q=%h err=%b", rsp_valid, rsp_quotient, rsp_err);
        check("rb_rsp_valid", 64'(rsp_valid), 64'(4'b0001));
        check("rb_quotient", 64'(rsp_quotient), 64'(16'h0800));
      end else @(negedge clk);
    end
    check("rb_rsp_seen", 64'(k), 64'd1);
    check("rb_no_rsp_during_reset", 64'(bad_rsp), 64'd0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
